// File: rtl/btn_input_pkg.sv
// Shared board constants for gm-proto-e1 input/output blocks and the
// per-channel button event bundle.
package btn_input_pkg;
  localparam int CLK_HZ   = 10_000_000;
  localparam int DEB_10MS = CLK_HZ / 100;
  localparam int LONG_1S  = CLK_HZ;

  typedef struct packed {
    logic state;
    logic press;
    logic rel;
    logic lp;
  } btn_ev_t;
endpackage

// File: rtl/btn_input_debounce_ch.sv
// One button channel: 2-FF sync, debounce, press/release edges and a
// one-shot long-press pulse.
module debounce_ch
  import btn_input_pkg::*;
#(
  parameter int DEB_CYCLES     = DEB_10MS,
  parameter int LONG_CYCLES    = LONG_1S,
  parameter bit BTN_ACTIVE_LOW = 1'b1
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    btn,
  output btn_ev_t ev
);
  localparam int   DW       = $clog2(DEB_CYCLES);
  localparam int   HW       = $clog2(LONG_CYCLES);
  localparam logic IDLE_LVL = BTN_ACTIVE_LOW;

  logic [1:0]    sync;
  logic          lvl, state, state_d, state_nxt, lp, lp_done;
  logic [DW-1:0] dcnt, dcnt_nxt;
  logic [HW-1:0] hcnt;

  assign lvl = sync[1] ^ BTN_ACTIVE_LOW;

  // Any sample agreeing with the current state restarts the count.
  always_comb begin
    state_nxt = state;
    dcnt_nxt  = '0;
    if (lvl != state) begin
      if (dcnt == DW'(DEB_CYCLES - 1)) state_nxt = lvl;
      else                              dcnt_nxt  = dcnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync    <= {2{IDLE_LVL}};
      dcnt    <= '0;
      state   <= 1'b0;
      state_d <= 1'b0;
      hcnt    <= '0;
      lp      <= 1'b0;
      lp_done <= 1'b0;
    end else begin
      sync    <= {sync[0], btn};
      dcnt    <= dcnt_nxt;
      state   <= state_nxt;
      state_d <= state;
      if (!state)                            hcnt <= '0;
      else if (hcnt != HW'(LONG_CYCLES - 1)) hcnt <= hcnt + 1'b1;
      // Gating on state_nxt lets a coincident release suppress the pulse.
      lp <= state_nxt && (hcnt == HW'(LONG_CYCLES - 1)) && !lp_done;
      if (!state_nxt)                                lp_done <= 1'b0;
      else if (hcnt == HW'(LONG_CYCLES - 1))         lp_done <= 1'b1;
    end
  end

  assign ev.state = state;
  assign ev.press = state & ~state_d;
  assign ev.rel   = ~state & state_d;
  assign ev.lp    = lp;
endmodule

// File: rtl/btn_input.sv
// Push-button front end: NBTN debounced channels plus a shared 4-bit
// counter of cycles carrying at least one press pulse.
module btn_input
  import btn_input_pkg::*;
#(
  parameter int NBTN           = 4,
  parameter int DEB_CYCLES     = DEB_10MS,
  parameter int LONG_CYCLES    = LONG_1S,
  parameter bit BTN_ACTIVE_LOW = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NBTN-1:0] btn,
  output logic [NBTN-1:0] state,
  output logic [NBTN-1:0] press,
  output logic [NBTN-1:0] rel,       // release pulse; "release" is a reserved word
  output logic [NBTN-1:0] longpress,
  output logic [3:0]      press_cnt
);
  btn_ev_t ev [NBTN];

  for (genvar i = 0; i < NBTN; i++) begin : g_ch
    debounce_ch #(
      .DEB_CYCLES    (DEB_CYCLES),
      .LONG_CYCLES   (LONG_CYCLES),
      .BTN_ACTIVE_LOW(BTN_ACTIVE_LOW)
    ) u_ch (
      .clk(clk),
      .rst(rst),
      .btn(btn[i]),
      .ev (ev[i])
    );
    assign state[i]     = ev[i].state;
    assign press[i]     = ev[i].press;
    assign rel[i]       = ev[i].rel;
    assign longpress[i] = ev[i].lp;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        press_cnt <= '0;
    else if (|press) press_cnt <= press_cnt + 4'd1;
  end
endmodule
